// File: rtl/fft_seq.sv
// fft_seq: frame sequencer for the streaming radix-2 FFT pipeline.
// It aligns the FFT stage counter with a one-cycle clear, requests N*nfrm
// contiguous input samples, waits for the pipeline to drain, and tags each
// output sample with valid, a bit-reversed bin index and frame markers.
module fft_seq #(
  parameter int unsigned CBW = 3,
  parameter int unsigned LAT = 7,
  parameter int unsigned FBW = 8
) (
  input  logic           clk,
  input  logic           rstx,
  input  logic           start,
  input  logic [FBW-1:0] nfrm,
  input  logic           abort,
  output logic           fft_clear,
  output logic           in_req,
  output logic           busy,
  output logic           out_valid,
  output logic [CBW-1:0] out_idx,
  output logic           out_first,
  output logic           out_last,
  output logic           done
);

  localparam int unsigned SW = CBW + FBW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]     state_q,     state_d;
  logic [FBW-1:0] nfrm_q,      nfrm_d;
  logic [SW-1:0]  scnt_q,      scnt_d;
  logic [CBW-1:0] ocnt_q,      ocnt_d;
  logic [LAT-1:0] vld_sr_q,    vld_sr_d;
  logic [LAT-1:0] mk_sr_q,     mk_sr_d;
  logic           fft_clear_q, fft_clear_d;
  logic           in_req_q,    in_req_d;
  logic           busy_q,      busy_d;
  logic           out_first_q, out_first_d;
  logic           done_q,      done_d;

  logic [SW-1:0]  run_last;
  logic           last_in;

  // Index of the final input sample: N*nfrm - 1, with N*nfrm as a shift.
  assign run_last = {nfrm_q, {CBW{1'b0}}} - SW'(1);
  assign last_in  = (state_q == S_RUN) && (scnt_q == run_last);

  // Next-state, counters, delay lines and registered output decode.
  always_comb begin
    state_d  = state_q;
    nfrm_d   = nfrm_q;
    scnt_d   = scnt_q;
    ocnt_d   = ocnt_q + CBW'(vld_sr_q[LAT-1]);
    done_d   = 1'b0;
    vld_sr_d = vld_sr_q;
    mk_sr_d  = mk_sr_q;

    // Delay lines: tap 0 tracks the current input cycle, the tail the output.
    for (int i = LAT - 1; i >= 1; i--) begin
      vld_sr_d[i] = vld_sr_q[i-1];
      mk_sr_d[i]  = mk_sr_q[i-1];
    end
    vld_sr_d[0] = in_req_q;
    mk_sr_d[0]  = last_in;

    case (state_q)
      S_IDLE: begin
        if (start && (nfrm != '0)) begin
          nfrm_d  = nfrm;
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        scnt_d  = '0;
        ocnt_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        scnt_d = scnt_q + SW'(1);
        if (last_in) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // The last-sample marker reaching the tail means the line is empty.
        if (mk_sr_q[LAT-1]) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start or completion.
    if (abort) begin
      state_d  = S_IDLE;
      vld_sr_d = '0;
      mk_sr_d  = '0;
      ocnt_d   = '0;
      done_d   = 1'b0;
    end

    fft_clear_d = (state_d == S_ALIGN);
    in_req_d    = (state_d == S_RUN);
    busy_d      = (state_d != S_IDLE);
    out_first_d = vld_sr_d[LAT-1] && (ocnt_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state_q     <= S_IDLE;
      nfrm_q      <= '0;
      scnt_q      <= '0;
      ocnt_q      <= '0;
      vld_sr_q    <= '0;
      mk_sr_q     <= '0;
      fft_clear_q <= 1'b0;
      in_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      out_first_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nfrm_q      <= nfrm_d;
      scnt_q      <= scnt_d;
      ocnt_q      <= ocnt_d;
      vld_sr_q    <= vld_sr_d;
      mk_sr_q     <= mk_sr_d;
      fft_clear_q <= fft_clear_d;
      in_req_q    <= in_req_d;
      busy_q      <= busy_d;
      out_first_q <= out_first_d;
      done_q      <= done_d;
    end
  end

  // Output bin index is the output counter with its bits reversed.
  always_comb begin
    out_idx = '0;
    for (int i = 0; i < CBW; i++) out_idx[i] = ocnt_q[CBW-1-i];
  end

  assign fft_clear = fft_clear_q;
  assign in_req    = in_req_q;
  assign busy      = busy_q;
  assign out_valid = vld_sr_q[LAT-1];
  assign out_first = out_first_q;
  assign out_last  = mk_sr_q[LAT-1];
  assign done      = done_q;

endmodule

// File: doc/fft_seq.md
# fft_seq

Frame sequencer for the streaming radix-2 FFT pipeline (N = 2^CBW points). It accepts a run request for a number of back-to-back frames and pulses the pipeline's synchronous `clear` so the stage counter is phase-aligned. It then pulls exactly N×nfrm input samples, flushes the pipeline, and tags each output sample with valid, bit-reversed bin index and frame markers. It sits between the sample source/sink and the FFT top, replacing ad-hoc `clear` generation.

## Interface
- CBW, 3, log2 of FFT size N; legal range 2..8
- LAT, 7, pipeline latency in cycles from the `din` of sample 0 to the `dout` of output 0; legal range 1..64
- FBW, 8, width of the frame-count input
- clk  input  1  clock, rising edge
- rstx  input  1  asynchronous active-low reset
- start  input  1  run request; honoured only in IDLE with nfrm≠0
- nfrm  input  FBW  frames to process; sampled with start
- abort  input  1  synchronous abort, any state
- fft_clear  output  1  drives the FFT `clear`; registered
- in_req  output  1  source must present a valid `din` this cycle; top level forces `din`=0 when low
- busy  output  1  state≠IDLE
- out_valid  output  1  FFT `dout` is a real output sample this cycle
- out_idx  output  CBW  frequency bin of the current output, bit-reversed output counter
- out_first  output  1  out_valid and bin position 0 of a frame
- out_last  output  1  out_valid and final sample of final frame
- done  output  1  one-cycle pulse after normal completion

## Operation
- States: IDLE, ALIGN, RUN, FLUSH.
- IDLE: start=1 and nfrm≠0 → latch nfrm, go to ALIGN. Start with nfrm=0 is ignored. Start outside IDLE is ignored.
- ALIGN (1 cycle): fft_clear=1. Sample counter scnt (CBW+FBW bits) is set to 0. Go to RUN.
- RUN: in_req=1 every cycle. scnt increments. When scnt = N×nfrm−1, go to FLUSH. The FFT counter is free-running, so the source must not stall inside RUN.
- FLUSH: in_req=0. Remain until the delay line is empty and the last out_valid has been emitted, then go to IDLE with done=1 for exactly one cycle.
- Valid tracking: an LAT-deep shift register carries in_req. out_valid is the shift register's tail. A separate marker shift register carries "last input sample" and yields out_last.
- Output counter ocnt (CBW bits): cleared in ALIGN; increments on out_valid and wraps mod N. out_idx = bit-reverse(ocnt). out_first = out_valid and ocnt=0.
- Abort: in any state, the next cycle is IDLE. Both shift registers and ocnt are cleared, so out_valid=0 from the next cycle. No done pulse. fft_clear is not asserted. Abort has priority over start in the same cycle.
- Arithmetic: N×nfrm is computed as {nfrm, CBW'b0}, with no multiplier. The maximum run is N×(2^FBW−1) samples.

## Timing
- Reset: all outputs 0, state IDLE, shift registers, scnt and ocnt at 0.
- All outputs are registered or decoded from registered state only; there is no input-to-output combinational path.
- Start accepted at edge T: fft_clear=1 during cycle T+1. in_req=1 during cycles T+2 … T+1+N×nfrm.
- First out_valid is at cycle T+2+LAT. out_valid stays high for N×nfrm consecutive cycles.
- out_last coincides with the final out_valid. done is high the following cycle, in which busy returns to 0.
- A new start is accepted on the cycle done is high (state IDLE).
- Reset mid-run: immediate return to reset values.

## Test plan
- CBW=3, LAT=7, start with nfrm=1 at cycle 0 -> fft_clear at cycle 1; in_req at cycles 2–9; out_valid at 9–16; out_idx sequence 0,4,2,6,1,5,3,7; out_first at 9; out_last at 16; done at 17.
- nfrm=3 -> in_req high for 24 contiguous cycles; 24 out_valid cycles; out_first at offsets 0, 8 and 16 of the valid run; a single out_last and a single done.
- start with nfrm=0, and start pulsed while busy -> no state change, no fft_clear; the in-progress run completes unchanged.
- abort asserted in the 4th RUN cycle, and separately in mid-FLUSH -> busy=0 and out_valid=0 from the next cycle; no done; a subsequent start with nfrm=1 behaves exactly as the first scenario.
- rstx pulled low mid-RUN, released, then start with nfrm=1 -> all outputs 0 during reset; the following run matches the first scenario.
- start held high continuously with nfrm=2 -> back-to-back runs; second fft_clear on the done cycle+1; no overlap of out_valid windows between runs.
